// File: rtl/vend_cdc_pkg.sv
// Shared definitions for the input-block to vending-FSM event links:
// channel state encoding, payload widths and default pulse timing.
package vend_cdc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } chan_state_e;

  localparam int unsigned CURRENCY_W       = 8;
  localparam int unsigned ITEM_W           = 10;

  localparam int unsigned DEF_HIGH_CYCLES  = 4;
  localparam int unsigned DEF_LOW_CYCLES   = 4;
  localparam int unsigned DEF_FIFO_DEPTH   = 4;

endpackage

// File: rtl/pulse_tx_chan.sv
// One event channel: push FIFO feeding a level-stretched valid/data
// transmitter whose outputs come straight from flops for safe CDC sampling.
module pulse_tx_chan
  import vend_cdc_pkg::*;
#(
  parameter int unsigned DW          = 8,
  parameter int unsigned DEPTH       = DEF_FIFO_DEPTH,
  parameter int unsigned HIGH_CYCLES = DEF_HIGH_CYCLES,
  parameter int unsigned LOW_CYCLES  = DEF_LOW_CYCLES
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push_valid,
  input  logic [DW-1:0] push_data,
  output logic          push_ready,
  input  logic          overflow_clr,
  output logic          overflow,
  output logic          valid_async,
  output logic [DW-1:0] data_async,
  output logic          busy
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CMAX = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          ready_en;
  logic          full;
  logic          empty;
  logic          push_ok;
  chan_state_e   state;
  logic [CW-1:0] cnt;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // ready_en holds ready low through reset and releases it one edge later
  assign push_ready = ready_en && !full;
  assign push_ok    = push_valid && push_ready;
  assign busy       = (state != IDLE) || !empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      ready_en <= 1'b0;
      overflow <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push_ok)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (overflow_clr)
        overflow <= 1'b0;
      else if (push_valid && !push_ready)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      valid_async <= 1'b0;
      data_async  <= '0;
      rd_ptr      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            data_async <= mem[rd_ptr[AW-1:0]];
            rd_ptr     <= rd_ptr + (AW+1)'(1);
            state      <= SETUP;
          end
        end
        SETUP: begin
          valid_async <= 1'b1;
          cnt         <= CW'(HIGH_CYCLES - 1);
          state       <= HIGH;
        end
        HIGH: begin
          if (cnt == '0) begin
            valid_async <= 1'b0;
            cnt         <= CW'(LOW_CYCLES - 1);
            state       <= LOW;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        LOW: begin
          if (cnt == '0)
            state <= IDLE;
          else
            cnt <= cnt - CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/input_cdc_tx.sv
// Input-block transmitter for the currency and item-select event links
// into the vending FSM clock domain; two independent pulse channels.
module input_cdc_tx
  import vend_cdc_pkg::*;
#(
  parameter int unsigned HIGH_CYCLES = DEF_HIGH_CYCLES,
  parameter int unsigned LOW_CYCLES  = DEF_LOW_CYCLES,
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                  clk_in,
  input  logic                  rstn,
  input  logic                  currency_valid,
  input  logic [CURRENCY_W-1:0] currency_value,
  output logic                  currency_ready,
  input  logic                  item_select_valid,
  input  logic [ITEM_W-1:0]     item_select,
  output logic                  item_select_ready,
  output logic                  currency_valid_async,
  output logic [CURRENCY_W-1:0] currency_value_async,
  output logic                  item_select_valid_async,
  output logic [ITEM_W-1:0]     item_select_async,
  input  logic                  overflow_clr,
  output logic                  currency_overflow,
  output logic                  item_overflow,
  output logic                  busy
);

  logic currency_busy;
  logic item_busy;

  pulse_tx_chan #(
    .DW          (CURRENCY_W),
    .DEPTH       (FIFO_DEPTH),
    .HIGH_CYCLES (HIGH_CYCLES),
    .LOW_CYCLES  (LOW_CYCLES)
  ) u_currency (
    .clk          (clk_in),
    .rstn         (rstn),
    .push_valid   (currency_valid),
    .push_data    (currency_value),
    .push_ready   (currency_ready),
    .overflow_clr (overflow_clr),
    .overflow     (currency_overflow),
    .valid_async  (currency_valid_async),
    .data_async   (currency_value_async),
    .busy         (currency_busy)
  );

  pulse_tx_chan #(
    .DW          (ITEM_W),
    .DEPTH       (FIFO_DEPTH),
    .HIGH_CYCLES (HIGH_CYCLES),
    .LOW_CYCLES  (LOW_CYCLES)
  ) u_item (
    .clk          (clk_in),
    .rstn         (rstn),
    .push_valid   (item_select_valid),
    .push_data    (item_select),
    .push_ready   (item_select_ready),
    .overflow_clr (overflow_clr),
    .overflow     (item_overflow),
    .valid_async  (item_select_valid_async),
    .data_async   (item_select_async),
    .busy         (item_busy)
  );

  assign busy = currency_busy | item_busy;

endmodule
